// File: rtl/countdown_led_driver_if.sv
// Bundle between the countdown counter/divider side and the LED panel driver.
// The master drives the level, arm flag and tick strobe. The slave (the driver) returns the panel outputs.
interface countdown_led_driver_if;
  logic       tick_en;
  logic       armed;
  logic [3:0] cnt_in;
  logic [7:0] leds;
  logic       boom;
  logic       done;

  modport master (
    output tick_en, armed, cnt_in,
    input  leds, boom, done
  );

  modport slave (
    input  tick_en, armed, cnt_in,
    output leds, boom, done
  );
endinterface

// File: rtl/countdown_led_driver.sv
// Turns the self-destruct countdown level into an 8-LED bar graph.
// The bar blinks faster as the level rises, and a flash sequence ends in all-on.
module countdown_led_driver #(
  parameter int LEVEL_MAX   = 8,
  parameter int BLINK_START = 5,
  parameter int DET_TICKS   = 6
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  countdown_led_driver_if.slave  bus_io
);
  localparam int         TW         = $clog2(LEVEL_MAX + 1);
  localparam int         DW         = $clog2(DET_TICKS + 1);
  localparam logic [3:0] LVL_MAX_C  = 4'(LEVEL_MAX);
  localparam logic [3:0] BLINK_C    = 4'(BLINK_START);
  localparam logic [DW-1:0] DET_C   = DW'(DET_TICKS);

  typedef enum logic [2:0] {S_IDLE, S_ARMED, S_BLINK, S_DET, S_DONE} state_t;

  state_t        state_q;
  logic [7:0]    leds_q;
  logic          boom_q;
  logic          done_q;
  logic [TW-1:0] tick_cnt_q;
  logic [DW-1:0] det_cnt_q;
  logic          phase_q;
  logic [3:0]    lvl_q;

  logic [3:0]    lvl;
  logic [7:0]    bar;
  logic [3:0]    half;
  logic          lvl_chg;
  logic          tick_wrap;
  logic          phase_d;
  logic [TW-1:0] tick_cnt_d;
  logic [DW-1:0] det_cnt_d;
  logic          det_last;
  state_t        arm_tgt;

  assign lvl = (bus_io.cnt_in > LVL_MAX_C) ? LVL_MAX_C : bus_io.cnt_in;

  for (genvar gi = 0; gi < 8; gi++) begin : g_bar
    assign bar[gi] = (lvl > 4'(gi));
  end

  always_comb begin
    half = LVL_MAX_C - lvl;
    if (half == 4'd0) begin
      half = 4'd1;
    end
    lvl_chg    = (lvl != lvl_q);
    tick_wrap  = bus_io.tick_en && (tick_cnt_q == TW'(half - 4'd1));
    // A level change restarts the half-period count but keeps the visible phase.
    phase_d    = phase_q ^ (tick_wrap && !lvl_chg);
    if (lvl_chg || tick_wrap) begin
      tick_cnt_d = '0;
    end else if (bus_io.tick_en) begin
      tick_cnt_d = tick_cnt_q + TW'(1);
    end else begin
      tick_cnt_d = tick_cnt_q;
    end
    det_cnt_d = det_cnt_q + DW'(1);
    det_last  = (det_cnt_d == DET_C);
    if (lvl >= LVL_MAX_C) begin
      arm_tgt = S_DET;
    end else if (lvl >= BLINK_C) begin
      arm_tgt = S_BLINK;
    end else begin
      arm_tgt = S_ARMED;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      leds_q     <= 8'h00;
      boom_q     <= 1'b0;
      done_q     <= 1'b0;
      tick_cnt_q <= '0;
      det_cnt_q  <= '0;
      phase_q    <= 1'b0;
      lvl_q      <= 4'd0;
    end else begin
      boom_q <= 1'b0;
      lvl_q  <= lvl;
      case (state_q)
        S_IDLE, S_ARMED, S_BLINK: begin
          if (!bus_io.armed) begin
            state_q    <= S_IDLE;
            leds_q     <= 8'h00;
            tick_cnt_q <= '0;
            phase_q    <= 1'b0;
          end else begin
            state_q <= arm_tgt;
            case (arm_tgt)
              S_DET: begin
                boom_q     <= 1'b1;
                leds_q     <= 8'hFF;
                det_cnt_q  <= '0;
                tick_cnt_q <= '0;
                phase_q    <= 1'b0;
              end
              S_BLINK: begin
                if (state_q == S_BLINK) begin
                  tick_cnt_q <= tick_cnt_d;
                  phase_q    <= phase_d;
                  leds_q     <= phase_d ? 8'h00 : bar;
                end else begin
                  tick_cnt_q <= '0;
                  phase_q    <= 1'b0;
                  leds_q     <= bar;
                end
              end
              default: begin
                tick_cnt_q <= '0;
                phase_q    <= 1'b0;
                leds_q     <= bar;
              end
            endcase
          end
        end
        S_DET: begin
          if (bus_io.tick_en) begin
            det_cnt_q <= det_cnt_d;
            if (det_last) begin
              state_q <= S_DONE;
              leds_q  <= 8'hFF;
              done_q  <= 1'b1;
            end else begin
              leds_q <= ~leds_q;
            end
          end
        end
        S_DONE: begin
          if (!bus_io.armed) begin
            state_q <= S_IDLE;
            leds_q  <= 8'h00;
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          leds_q  <= 8'h00;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus_io.leds = leds_q;
  assign bus_io.boom = boom_q;
  assign bus_io.done = done_q;
endmodule

// File: tb/tb_countdown_led_driver.sv
// Directed bench for the countdown LED driver: expectations are queued as stimulus is driven
// and compared against the registered outputs one clock later.
module tb_countdown_led_driver;
  logic clk;
  logic rst;

  countdown_led_driver_if bus ();

  countdown_led_driver dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus_io  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] leds;
    logic       boom;
    logic       done;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic push_exp(input logic [7:0] el, input logic eb, input logic ed, input string tag);
    exp_t e;
    e.leds = el;
    e.boom = eb;
    e.done = ed;
    e.tag  = tag;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      n_assert++;
      n_fail++;
      $display("FAIL scoreboard_empty: got no expectation, required one");
      return;
    end
    e = sb.pop_front();
    n_assert++;
    assert (bus.leds === e.leds) else begin
      n_fail++;
      $error("FAIL %s leds: got %h required %h", e.tag, bus.leds, e.leds);
    end
    n_assert++;
    assert (bus.boom === e.boom) else begin
      n_fail++;
      $error("FAIL %s boom: got %b required %b", e.tag, bus.boom, e.boom);
    end
    n_assert++;
    assert (bus.done === e.done) else begin
      n_fail++;
      $error("FAIL %s done: got %b required %b", e.tag, bus.done, e.done);
    end
  endtask

  // Drive one clock of stimulus, then compare the outputs it produces.
  task automatic step(input logic a, input logic [3:0] c, input logic t,
                      input logic [7:0] el, input logic eb, input logic ed, input string tag);
    @(negedge clk);
    bus.armed   = a;
    bus.cnt_in  = c;
    bus.tick_en = t;
    push_exp(el, eb, ed, tag);
    @(posedge clk);
    #1;
    check_out();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] e;
    logic       a;
    rst         = 1'b1;
    bus.armed   = 1'b1;
    bus.cnt_in  = 4'd3;
    bus.tick_en = 1'b0;

    // 1) outputs held at zero through reset, bar appears one clock after release
    repeat (2) @(negedge clk);
    push_exp(8'h00, 1'b0, 1'b0, "in_reset");
    check_out();
    @(negedge clk);
    rst = 1'b0;
    push_exp(8'h07, 1'b0, 1'b0, "release_armed3");
    @(posedge clk);
    #1;
    check_out();

    // 2) bar graph below blink threshold, ticks have no effect
    step(1, 4'd0, 0, 8'h00, 0, 0, "bar0");
    step(1, 4'd1, 0, 8'h01, 0, 0, "bar1");
    step(1, 4'd2, 0, 8'h03, 0, 0, "bar2");
    step(1, 4'd3, 0, 8'h07, 0, 0, "bar3");
    step(1, 4'd4, 0, 8'h0F, 0, 0, "bar4");
    step(1, 4'd4, 1, 8'h0F, 0, 0, "bar4_tick");

    // 3) level 5 blinks with a 3-tick half period, level 7 toggles every tick
    step(1, 4'd5, 0, 8'h1F, 0, 0, "blink5_entry");
    for (int k = 1; k <= 9; k++) begin
      e = (((k / 3) % 2) == 1) ? 8'h00 : 8'h1F;
      step(1, 4'd5, 1, e, 0, 0, "blink5_tick");
      for (int j = 0; j < 3; j++) step(1, 4'd5, 0, e, 0, 0, "blink5_hold");
    end
    step(1, 4'd7, 0, 8'h00, 0, 0, "blink7_lvlchg_keeps_phase");
    for (int k = 1; k <= 4; k++) begin
      e = (k % 2 == 1) ? 8'h7F : 8'h00;
      step(1, 4'd7, 1, e, 0, 0, "blink7_tick");
      step(1, 4'd7, 0, e, 0, 0, "blink7_hold");
    end

    // 5) disarm wins over detonation level; tick on BLINK entry is not counted
    step(0, 4'd8, 0, 8'h00, 0, 0, "abort_to_idle");
    step(0, 4'd8, 0, 8'h00, 0, 0, "abort_no_boom");
    step(1, 4'd2, 0, 8'h03, 0, 0, "rearm2");
    step(1, 4'd6, 1, 8'h3F, 0, 0, "blink6_entry_tick");
    step(1, 4'd6, 1, 8'h3F, 0, 0, "blink6_tick1");
    step(1, 4'd6, 1, 8'h00, 0, 0, "blink6_tick2");

    // 4) detonation via clamped level, disarm mid-flash, DONE then back to IDLE
    step(1, 4'd15, 0, 8'hFF, 1, 0, "det_entry_clamped");
    step(1, 4'd15, 0, 8'hFF, 0, 0, "det_boom_single");
    for (int k = 1; k <= 6; k++) begin
      a = (k < 3);
      if (k < 6) begin
        e = (k % 2 == 1) ? 8'h00 : 8'hFF;
        step(a, 4'd15, 1, e, 0, 0, "det_flash_tick");
        step(a, 4'd15, 0, e, 0, 0, "det_flash_hold");
      end else begin
        step(a, 4'd15, 1, 8'hFF, 0, 1, "det_done");
        step(a, 4'd15, 0, 8'h00, 0, 0, "done_to_idle");
      end
    end

    // 6) asynchronous reset while boom is high, then a clean restart to DONE
    step(1, 4'd8, 0, 8'hFF, 1, 0, "det_direct_from_idle");
    #1;
    rst = 1'b1;
    #1;
    push_exp(8'h00, 1'b0, 1'b0, "async_reset_in_det");
    check_out();
    @(negedge clk);
    bus.armed = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    step(0, 4'd8, 0, 8'h00, 0, 0, "post_reset_idle");
    step(1, 4'd8, 0, 8'hFF, 1, 0, "restart_det");
    for (int k = 1; k <= 6; k++) begin
      if (k < 6) begin
        e = (k % 2 == 1) ? 8'h00 : 8'hFF;
        step(1, 4'd8, 1, e, 0, 0, "restart_flash");
      end else begin
        step(1, 4'd8, 1, 8'hFF, 0, 1, "restart_done");
      end
    end
    step(1, 4'd8, 1, 8'hFF, 0, 1, "done_hold");
    step(1, 4'd0, 0, 8'hFF, 0, 1, "done_ignores_cnt");
    step(0, 4'd0, 0, 8'h00, 0, 0, "done_disarm_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
